qed_trace_reader: RTL and testbench
===================================

Name: qed_trace_reader

Overview:
- Read-side companion to the QED trace capture buffer (the dual MEM_WB_PACKET circular FIFOs that freeze on fault).
- Once the capture side reports has_fault_occured, this block replays both frozen traces oldest-first as paired beats on a valid/ready stream.
- Each beat carries a per-entry mismatch flag, and the block records the first divergent age index.
- It sits beside the capture block and feeds the debug/trace export path or a testbench monitor.

Parameters:
- FIFO_SIZE, 16, entries per trace; must match the capture block; power of two, ≥2.
- IW, $clog2(FIFO_SIZE), index/head width (derived, not overridable).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- trace1  in  MEM_WB_PACKET[FIFO_SIZE]  frozen FIFO1 contents from capture block
- trace2  in  MEM_WB_PACKET[FIFO_SIZE]  frozen FIFO2 contents
- head1  in  IW  capture FIFO1 write pointer (next slot to write)
- head2  in  IW  capture FIFO2 write pointer
- has_fault_occured  in  1  capture-side freeze flag (registered, sticky until reset)
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts beat
- out_pkt1  out  MEM_WB_PACKET  trace1 entry for this beat
- out_pkt2  out  MEM_WB_PACKET  trace2 entry for this beat
- out_idx  out  IW  age index of beat (0 = oldest)
- out_mismatch  out  1  out_pkt1 != out_pkt2 (full-packet compare)
- out_last  out  1  final beat of dump
- dump_done  out  1  dump complete; sticky until reset
- mismatch_found  out  1  any beat so far mismatched; sticky
- first_mismatch_idx  out  IW  out_idx of first mismatching beat; valid when mismatch_found

Behaviour:
- Reset: state=IDLE, fill=0, ptr=0, beat=0, out_valid=0, out_last=0, dump_done=0, mismatch_found=0, first_mismatch_idx=0. out_pkt1/out_pkt2/out_mismatch are don't-care while out_valid=0; drive them to 0.
- Fill counter, width IW+1:
  - Increments each cycle with reset=0 and has_fault_occured=0. This is exactly the capture side's write condition.
  - Saturates at FIFO_SIZE.
  - Frozen once has_fault_occured=1.
- States:
  - IDLE: wait for has_fault_occured=1, then go to LOAD.
  - LOAD (1 cycle): latch count=fill.
    - Latch rd1=(head1-fill) mod FIFO_SIZE and rd2=(head2-fill) mod FIFO_SIZE, i.e. the oldest slots.
    - beat=0.
    - If fill==0, go to DONE (no beats). Otherwise go to DUMP.
  - DUMP:
    - out_valid=1.
    - out_pkt1=trace1[rd1], out_pkt2=trace2[rd2], combinational from the frozen arrays; out_idx=beat.
    - out_last=(beat==count-1).
    - On out_valid&&out_ready: rd1/rd2 increment with wrap FIFO_SIZE-1→0, and beat increments.
    - If out_last on that handshake, go to DONE.
    - Throughput: 1 beat/cycle.
    - First out_valid appears 2 cycles after has_fault_occured is first sampled high.
  - DONE: out_valid=0, dump_done=1. Stays until reset; no re-arm without reset.
- Handshake:
  - While out_valid=1 and out_ready=0, all out_* fields hold stable.
  - out_ready is ignored outside DUMP.
- Mismatch tracking:
  - On each handshake with out_mismatch=1 and mismatch_found=0: set mismatch_found=1 and first_mismatch_idx=out_idx.
  - Later mismatches do not overwrite first_mismatch_idx.
- Independent heads: rd1 and rd2 are derived independently from head1 and head2. Normally head1==head2; no check is required.
- Boundaries:
  - fill<FIFO_SIZE: oldest slot = head-fill = 0 (no wrap yet).
  - fill==FIFO_SIZE: oldest slot = head; a full FIFO_SIZE beats are emitted.
  - Reset in any state, including mid-DUMP with out_valid=1: returns to reset values next cycle. Any beat not yet handshaken is dropped.
  - has_fault_occured dropping without reset: the capture side never does this; the block ignores it after leaving IDLE.

Test Plan:
- FIFO_SIZE=16; capture 5 writes (pkt1=pkt2=A0..A4), then fault; out_ready=1 -> out_valid 2 cycles after freeze.
  - 5 beats, out_idx 0..4, data A0..A4; out_last on beat 4.
  - dump_done=1 next cycle; mismatch_found=0.
- FIFO_SIZE=16; 20 writes B0..B19 then fault (head=4) -> 16 beats.
  - Beat0=B4 (slot 4), beat11=B15 (slot 15), beat12=B16 (slot 0, wrap), beat15=B19 (slot 3).
- Backpressure: 10 writes; drop out_ready for 3 cycles while beat 3 is presented.
  - Beat 3 fields held constant for those 3 cycles; no beat skipped or duplicated; total 10 handshakes.
- Divergence: 10 writes; pkt2 differs at writes 7 and 9.
  - out_mismatch=1 on beats 7 and 9 only.
  - mismatch_found=1 after beat 7; first_mismatch_idx=7 (not 9) at dump_done.
- Zero fill: has_fault_occured=1 in the first cycle after reset deasserts.
  - fill=0; no out_valid ever; dump_done=1 two cycles later.
- Reset mid-dump: 16-entry dump with reset asserted at beat 6.
  - Next cycle all outputs at reset values.
  - A fresh capture of 3 writes + fault then dumps 3 beats from idx 0.

Source files
------------

// File: rtl/qed_trace_if.sv
// Replay stream from qed_trace_reader: one paired trace beat per handshake.
// A beat transfers on a rising clk edge where out_valid && out_ready; while out_valid=1 and
// out_ready=0 every out_* field holds stable, and out_valid never drops without a transfer.
interface qed_trace_if #(
  parameter int FIFO_SIZE = 16,
  parameter int PKT_W     = 32
);
  localparam int IW = $clog2(FIFO_SIZE);

  logic             out_valid;
  logic             out_ready;
  logic [PKT_W-1:0] out_pkt1;
  logic [PKT_W-1:0] out_pkt2;
  logic [IW-1:0]    out_idx;
  logic             out_mismatch;
  logic             out_last;

  modport master (
    output out_valid, out_pkt1, out_pkt2, out_idx, out_mismatch, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_pkt1, out_pkt2, out_idx, out_mismatch, out_last,
    output out_ready
  );
endinterface

// File: rtl/qed_trace_reader.sv
// Replays the two frozen QED capture FIFOs oldest-first as paired beats once a fault freezes them,
// flagging per-beat divergence and remembering the first divergent age index.
module qed_trace_reader #(
  parameter  int FIFO_SIZE = 16,
  parameter  int PKT_W     = 32,
  localparam int IW        = $clog2(FIFO_SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PKT_W-1:0] trace1 [FIFO_SIZE],
  input  logic [PKT_W-1:0] trace2 [FIFO_SIZE],
  input  logic [IW-1:0]    head1,
  input  logic [IW-1:0]    head2,
  input  logic             has_fault_occured,
  qed_trace_if.master      stream,
  output logic             dump_done,
  output logic             mismatch_found,
  output logic [IW-1:0]    first_mismatch_idx,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DUMP = 2'd2, DONE = 2'd3} state_t;

  state_t        state, state_nxt;
  logic [IW:0]   fill;
  logic [IW:0]   count;
  logic [IW-1:0] rd1, rd2, beat;
  logic          hs;
  logic          last;

  // Mirrors the capture side's write condition so fill equals the number of valid entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill <= '0;
    end else if (!has_fault_occured && fill != (IW+1)'(FIFO_SIZE)) begin
      fill <= fill + (IW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (has_fault_occured) state_nxt = LOAD;
      LOAD: state_nxt = (fill == '0) ? DONE : DUMP;
      DUMP: if (hs && last) state_nxt = DONE;
      DONE: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Oldest slot is head-fill; when full, fill's low bits are zero so the oldest is head itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      rd1   <= '0;
      rd2   <= '0;
      beat  <= '0;
    end else if (state == LOAD) begin
      count <= fill;
      rd1   <= head1 - fill[IW-1:0];
      rd2   <= head2 - fill[IW-1:0];
      beat  <= '0;
    end else if (hs) begin
      rd1   <= rd1 + IW'(1);
      rd2   <= rd2 + IW'(1);
      beat  <= beat + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch_found     <= 1'b0;
      first_mismatch_idx <= '0;
    end else if (hs && stream.out_mismatch && !mismatch_found) begin
      mismatch_found     <= 1'b1;
      first_mismatch_idx <= beat;
    end
  end

  assign hs   = (state == DUMP) && stream.out_ready;
  assign last = (state == DUMP) && ({1'b0, beat} == count - (IW+1)'(1));

  always_comb begin
    stream.out_valid    = 1'b0;
    stream.out_pkt1     = '0;
    stream.out_pkt2     = '0;
    stream.out_idx      = beat;
    stream.out_mismatch = 1'b0;
    stream.out_last     = 1'b0;
    dump_done           = 1'b0;
    case (state)
      DUMP: begin
        stream.out_valid    = 1'b1;
        stream.out_pkt1     = trace1[rd1];
        stream.out_pkt2     = trace2[rd2];
        stream.out_mismatch = (trace1[rd1] != trace2[rd2]);
        stream.out_last     = last;
      end
      DONE:    dump_done = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_qed_trace_reader.sv
// Directed bench for qed_trace_reader: models the capture FIFOs and checks each replay scenario.
module tb_qed_trace_reader;
  localparam int FS = 16;
  localparam int IW = 4;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] trace1 [FS];
  logic [PW-1:0] trace2 [FS];
  logic [IW-1:0] head1, head2;
  logic          fault;
  logic          dump_done, mismatch_found;
  logic [IW-1:0] first_mismatch_idx;
  logic [1:0]    state_dbg;

  qed_trace_if #(.FIFO_SIZE(FS), .PKT_W(PW)) bus ();

  qed_trace_reader #(.FIFO_SIZE(FS), .PKT_W(PW)) dut (
    .clk                (clk),
    .reset              (reset),
    .trace1             (trace1),
    .trace2             (trace2),
    .head1              (head1),
    .head2              (head2),
    .has_fault_occured  (fault),
    .stream             (bus),
    .dump_done          (dump_done),
    .mismatch_found     (mismatch_found),
    .first_mismatch_idx (first_mismatch_idx),
    .state_dbg          (state_dbg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [PW-1:0] exp_q [$];
  logic [PW-1:0] got_p1 [$];
  logic [PW-1:0] got_p2 [$];
  logic [IW-1:0] got_idx [$];
  logic          got_last [$];
  logic          got_mm [$];
  logic          got_mf [$];
  int            first_valid_cyc, last_cyc, done_cyc, valid_cycles;
  logic          timed_out;

  // Clock/reset block: reset spans two edges, capture model heads cleared alongside.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    fault = 1'b0;
    bus.out_ready = 1'b1;
    head1 = '0;
    head2 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Capture model: one write per clock while unfrozen, then freeze.
  task automatic capture(input int n, input logic [PW-1:0] base, input logic [31:0] diff_mask);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      trace1[head1] = base + PW'(i);
      trace2[head2] = diff_mask[i] ? ~(base + PW'(i)) : base + PW'(i);
      head1 = head1 + IW'(1);
      head2 = head2 + IW'(1);
    end
    fault = 1'b1;
  endtask

  // Observes the stream until dump_done, recording every handshaken beat.
  task automatic drain(input int max_cyc);
    got_p1.delete(); got_p2.delete(); got_idx.delete();
    got_last.delete(); got_mm.delete(); got_mf.delete();
    first_valid_cyc = -1; last_cyc = -1; done_cyc = -1; valid_cycles = 0;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(negedge clk);
      if (dump_done) begin
        done_cyc = cyc;
        break;
      end
      if (bus.out_valid) begin
        valid_cycles++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        got_p1.push_back(bus.out_pkt1);
        got_p2.push_back(bus.out_pkt2);
        got_idx.push_back(bus.out_idx);
        got_last.push_back(bus.out_last);
        got_mm.push_back(bus.out_mismatch);
        got_mf.push_back(mismatch_found);
        if (bus.out_last) last_cyc = cyc;
      end
    end
    timed_out = (done_cyc < 0);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b want 0", bus.out_last); end
    n_cmp++; if (dump_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", dump_done); end
    n_cmp++; if (mismatch_found !== 1'b0) begin n_bad++; $display("FAIL reset_mf: got %b want 0", mismatch_found); end
    n_cmp++; if (first_mismatch_idx !== '0) begin n_bad++; $display("FAIL reset_fmi: got %0d want 0", first_mismatch_idx); end
    n_cmp++; if (bus.out_pkt1 !== '0 || bus.out_pkt2 !== '0) begin n_bad++; $display("FAIL reset_pkt: got %h/%h want 0/0", bus.out_pkt1, bus.out_pkt2); end
    n_cmp++; if (state_dbg !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
  endtask

  task automatic test_basic();
    do_reset();
    capture(5, 32'hA000_0000, 32'h0);
    drain(60);
    exp_q.delete();
    for (int k = 0; k < 5; k++) exp_q.push_back(32'hA000_0000 + PW'(k));
    n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL basic_timeout: got %b want 0", timed_out); end
    n_cmp++; if (first_valid_cyc != 2) begin n_bad++; $display("FAIL basic_latency: got %0d want 2", first_valid_cyc); end
    n_cmp++; if (got_p1.size() != 5) begin n_bad++; $display("FAIL basic_count: got %0d want 5", got_p1.size()); end
    for (int k = 0; k < 5 && k < got_p1.size(); k++) begin
      n_cmp++; if (got_p1[k] !== exp_q[k] || got_p2[k] !== exp_q[k]) begin n_bad++; $display("FAIL basic_data[%0d]: got %h/%h want %h", k, got_p1[k], got_p2[k], exp_q[k]); end
      n_cmp++; if (got_idx[k] !== IW'(k)) begin n_bad++; $display("FAIL basic_idx[%0d]: got %0d want %0d", k, got_idx[k], k); end
      n_cmp++; if (got_last[k] !== (k == 4)) begin n_bad++; $display("FAIL basic_last[%0d]: got %b want %b", k, got_last[k], (k == 4)); end
      n_cmp++; if (got_mm[k] !== 1'b0) begin n_bad++; $display("FAIL basic_mm[%0d]: got %b want 0", k, got_mm[k]); end
    end
    n_cmp++; if (done_cyc - last_cyc != 1) begin n_bad++; $display("FAIL basic_done_delay: got %0d want 1", done_cyc - last_cyc); end
    n_cmp++; if (mismatch_found !== 1'b0) begin n_bad++; $display("FAIL basic_mf: got %b want 0", mismatch_found); end
    n_cmp++; if (state_dbg !== 2'd3) begin n_bad++; $display("FAIL basic_state: got %0d want 3", state_dbg); end
  endtask

  task automatic test_wrap();
    do_reset();
    capture(20, 32'hB000_0000, 32'h0);
    drain(80);
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back(32'hB000_0000 + PW'(4 + k));
    n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL wrap_timeout: got %b want 0", timed_out); end
    n_cmp++; if (got_p1.size() != 16) begin n_bad++; $display("FAIL wrap_count: got %0d want 16", got_p1.size()); end
    for (int k = 0; k < 16 && k < got_p1.size(); k++) begin
      n_cmp++; if (got_p1[k] !== exp_q[k] || got_p2[k] !== exp_q[k]) begin n_bad++; $display("FAIL wrap_data[%0d]: got %h/%h want %h", k, got_p1[k], got_p2[k], exp_q[k]); end
      n_cmp++; if (got_idx[k] !== IW'(k) || got_last[k] !== (k == 15)) begin n_bad++; $display("FAIL wrap_idx_last[%0d]: got %0d/%b want %0d/%b", k, got_idx[k], got_last[k], k, (k == 15)); end
    end
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] snap_p1;
    logic          stalled;
    do_reset();
    capture(10, 32'hC000_0000, 32'h0);
    got_p1.delete(); got_idx.delete();
    stalled = 1'b0;
    for (int cyc = 0; cyc < 100 && !dump_done; cyc++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_idx == IW'(3) && !stalled) begin
        stalled = 1'b1;
        snap_p1 = bus.out_pkt1;
        bus.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_idx !== IW'(3) || bus.out_pkt1 !== snap_p1 || bus.out_pkt2 !== 32'hC000_0003 || bus.out_last !== 1'b0) begin
            n_bad++; $display("FAIL bp_hold: got v=%b idx=%0d p1=%h p2=%h want v=1 idx=3 p1=%h p2=c0000003", bus.out_valid, bus.out_idx, bus.out_pkt1, bus.out_pkt2, snap_p1);
          end
        end
        bus.out_ready = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        got_p1.push_back(bus.out_pkt1);
        got_idx.push_back(bus.out_idx);
      end
    end
    n_cmp++; if (stalled !== 1'b1) begin n_bad++; $display("FAIL bp_stall_seen: got %b want 1", stalled); end
    n_cmp++; if (dump_done !== 1'b1) begin n_bad++; $display("FAIL bp_done: got %b want 1", dump_done); end
    n_cmp++; if (got_p1.size() != 10) begin n_bad++; $display("FAIL bp_count: got %0d want 10", got_p1.size()); end
    for (int k = 0; k < 10 && k < got_p1.size(); k++) begin
      n_cmp++; if (got_p1[k] !== 32'hC000_0000 + PW'(k) || got_idx[k] !== IW'(k)) begin n_bad++; $display("FAIL bp_beat[%0d]: got %h/%0d want %h/%0d", k, got_p1[k], got_idx[k], 32'hC000_0000 + PW'(k), k); end
    end
  endtask

  task automatic test_divergence();
    do_reset();
    capture(10, 32'hD000_0000, 32'h0000_0280);
    drain(60);
    n_cmp++; if (got_p1.size() != 10) begin n_bad++; $display("FAIL div_count: got %0d want 10", got_p1.size()); end
    for (int k = 0; k < 10 && k < got_p1.size(); k++) begin
      n_cmp++; if (got_mm[k] !== (k == 7 || k == 9)) begin n_bad++; $display("FAIL div_mm[%0d]: got %b want %b", k, got_mm[k], (k == 7 || k == 9)); end
      n_cmp++; if (got_mf[k] !== (k > 7)) begin n_bad++; $display("FAIL div_mf_before[%0d]: got %b want %b", k, got_mf[k], (k > 7)); end
    end
    n_cmp++; if (got_p2.size() > 9 && got_p2[9] !== ~(32'hD000_0009)) begin n_bad++; $display("FAIL div_pkt2_9: got %h want %h", got_p2[9], ~(32'hD000_0009)); end
    n_cmp++; if (mismatch_found !== 1'b1) begin n_bad++; $display("FAIL div_mf: got %b want 1", mismatch_found); end
    n_cmp++; if (first_mismatch_idx !== IW'(7)) begin n_bad++; $display("FAIL div_first_idx: got %0d want 7", first_mismatch_idx); end
  endtask

  task automatic test_zero_fill();
    do_reset();
    capture(0, 32'h0, 32'h0);
    drain(20);
    n_cmp++; if (valid_cycles != 0) begin n_bad++; $display("FAIL zero_valid: got %0d want 0", valid_cycles); end
    n_cmp++; if (done_cyc != 2) begin n_bad++; $display("FAIL zero_done_cyc: got %0d want 2", done_cyc); end
  endtask

  task automatic test_reset_mid_dump();
    logic found;
    do_reset();
    capture(16, 32'hE000_0000, 32'h0);
    found = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_idx == IW'(6)) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL mid_beat6_seen: got %b want 1", found); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_mismatch !== 1'b0) begin n_bad++; $display("FAIL mid_reset_flags: got v=%b l=%b m=%b want 0/0/0", bus.out_valid, bus.out_last, bus.out_mismatch); end
    n_cmp++; if (bus.out_pkt1 !== '0 || bus.out_pkt2 !== '0 || bus.out_idx !== '0) begin n_bad++; $display("FAIL mid_reset_fields: got %h/%h/%0d want 0/0/0", bus.out_pkt1, bus.out_pkt2, bus.out_idx); end
    n_cmp++; if (dump_done !== 1'b0 || mismatch_found !== 1'b0 || first_mismatch_idx !== '0 || state_dbg !== 2'd0) begin n_bad++; $display("FAIL mid_reset_status: got d=%b mf=%b fmi=%0d st=%0d want 0/0/0/0", dump_done, mismatch_found, first_mismatch_idx, state_dbg); end
    fault = 1'b0;
    head1 = '0;
    head2 = '0;
    reset = 1'b0;
    capture(3, 32'hF000_0000, 32'h0);
    drain(40);
    n_cmp++; if (got_p1.size() != 3) begin n_bad++; $display("FAIL mid_re_count: got %0d want 3", got_p1.size()); end
    for (int k = 0; k < 3 && k < got_p1.size(); k++) begin
      n_cmp++; if (got_p1[k] !== 32'hF000_0000 + PW'(k) || got_idx[k] !== IW'(k) || got_last[k] !== (k == 2)) begin n_bad++; $display("FAIL mid_re_beat[%0d]: got %h/%0d/%b want %h/%0d/%b", k, got_p1[k], got_idx[k], got_last[k], 32'hF000_0000 + PW'(k), k, (k == 2)); end
    end
  endtask

  initial begin
    reset = 1'b1;
    fault = 1'b0;
    head1 = '0;
    head2 = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < FS; i++) begin
      trace1[i] = '0;
      trace2[i] = '0;
    end
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_divergence();
    test_zero_fill();
    test_reset_mid_dump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
